// File: rtl/if_fetch_queue_pkg.sv
// Shared widths, constants and the prefetch-queue entry layout for the IF fetch queue.
// Also provides the sequential PC step helper used by the top.
package if_fetch_queue_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
  localparam logic [PC_W-1:0]    PC_STEP   = 32'd4;

  // One prefetch-queue slot: the fetched word together with its PC+4.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc_incr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_fetch_queue_sync_fifo.sv
// Generic synchronous FIFO with clear, occupancy count and combinational head.
// DEPTH need not be a power of two; pointers wrap explicitly.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: issues sequential imem reads, buffers returned words with
// their PC+4 and presents the queue head to IF/ID, flushing on redirect.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int              DEPTH      = 4,
  parameter int              MAX_OUTSTD = 2,
  parameter logic [PC_W-1:0] RESET_PC   = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               id_stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_incr_out
);

  localparam int QCNT_W = $clog2(DEPTH + 1);
  localparam int IN_W   = $clog2(MAX_OUTSTD + 1);
  localparam int OCC_W  = $clog2(DEPTH + MAX_OUTSTD + 1);

  logic [PC_W-1:0]   fetch_pc;
  logic              run;
  logic [IN_W-1:0]   discard;
  logic [IN_W-1:0]   inflight;
  logic [QCNT_W-1:0] q_count;
  logic              q_full;
  logic              q_empty;
  logic              tag_full;
  logic              tag_empty;
  logic [PC_W-1:0]   tag_head;
  fetch_entry_t      q_head;
  fetch_entry_t      q_push_data;
  logic [OCC_W-1:0]  occupancy;
  logic              issue;
  logic              rsp;
  logic              keep_word;
  logic              pop_head;

  // Counting in-flight reads against queue space means a response can never overflow.
  assign occupancy = OCC_W'(q_count) + OCC_W'(inflight);
  assign imem_req  = run && !redirect && !tag_full && !q_full &&
                     (occupancy < OCC_W'(DEPTH));
  assign imem_addr = fetch_pc;
  assign issue     = imem_req && imem_gnt;

  // A response with nothing outstanding (e.g. one issued before reset) is ignored.
  assign rsp       = imem_rvalid && !tag_empty;
  assign keep_word = rsp && (discard == '0) && !redirect;
  assign pop_head  = !q_empty && !id_stall && !redirect;

  assign q_push_data.instr   = imem_rdata;
  assign q_push_data.pc_incr = tag_head;

  // Tag FIFO: PC+4 of every issued read; its occupancy is the in-flight count.
  sync_fifo #(
    .W    (PC_W),
    .DEPTH(MAX_OUTSTD)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (1'b0),
    .push     (issue),
    .push_data(pc_next(fetch_pc)),
    .pop      (rsp),
    .head     (tag_head),
    .count    (inflight),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  sync_fifo #(
    .W    (ENTRY_W),
    .DEPTH(DEPTH)
  ) u_instr_queue (
    .clk      (clk),
    .rst      (rst),
    .clr      (redirect),
    .push     (keep_word),
    .push_data(q_push_data),
    .pop      (pop_head),
    .head     (q_head),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty)
  );

  // run holds off requests for the first cycle after any reset edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      discard  <= '0;
      run      <= 1'b0;
    end else begin
      run <= 1'b1;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        discard  <= rsp ? inflight - IN_W'(1) : inflight;
      end else begin
        if (issue) fetch_pc <= pc_next(fetch_pc);
        if (rsp && (discard != '0)) discard <= discard - IN_W'(1);
      end
    end
  end

  assign instr_valid = !q_empty;
  assign instr_out   = instr_valid ? q_head.instr : NOP_INSTR;
  assign pc_incr_out = instr_valid ? q_head.pc_incr : '0;

endmodule
